shot_responder: RTL



---
 rtl/warships_pkg.sv | 33 +++
 rtl/sync_2ff.sv | 20 ++
 rtl/shot_responder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/warships_pkg.sv
// Shared types for the warships boards: cell encoding, coordinate layout and
// the shot responder state set.
package warships_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        SHIP  = 2'b01,
        MISS  = 2'b10,
        HIT   = 2'b11
    } cell_t;

    localparam int CORD_W = 8;
    localparam int X_HI   = 7;
    localparam int X_LO   = 4;
    localparam int Y_HI   = 3;
    localparam int Y_LO   = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EVAL,
        S_ACK
    } resp_state_t;

    function automatic logic [X_HI-X_LO:0] cord_x(input logic [CORD_W-1:0] c);
        return c[X_HI:X_LO];
    endfunction

    function automatic logic [Y_HI-Y_LO:0] cord_y(input logic [CORD_W-1:0] c);
        return c[Y_HI:Y_LO];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchroniser for a single asynchronous level (ready2, hit2).
module sync_2ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff <= '0;
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/shot_responder.sv
// Answers opponent shots: looks the target up on the local board, marks it
// hit/miss, and returns the verdict over a four-phase ready1/ready2 handshake.
module shot_responder
    import warships_pkg::*;
#(
    parameter int X_SIZE      = 12,
    parameter int Y_SIZE      = 12,
    parameter int SHIP_CELLS  = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            new_game,
    input  logic                            ready2,
    input  logic [CORD_W-1:0]               ship_cords_in,
    output logic                            ready1,
    output logic                            hit1,
    output logic [CORD_W-1:0]               mem_addr,
    input  logic [1:0]                      mem_rdata,
    output logic [1:0]                      mem_wdata,
    output logic                            mem_w_nr,
    output logic                            busy,
    output logic [$clog2(SHIP_CELLS+1)-1:0] cells_left,
    output logic                            all_sunk,
    output logic                            bad_cords
);

    localparam int CL_W = $clog2(SHIP_CELLS+1);

    resp_state_t       state, state_n;
    logic              r2_s, r2_d, r2_rise;
    logic [SYNC_STAGES-1:0] settle;
    logic [CORD_W-1:0] cords_q;
    logic              latch, dec, out_of_range;
    logic              ready1_n, hit1_n, wr_n, bad_n;
    logic [1:0]        wdata_n;
    logic [CL_W-1:0]   cells_n;

    sync_2ff #(.STAGES(SYNC_STAGES)) u_r2_sync (
        .clk (clk),
        .rst (rst),
        .d   (ready2),
        .q   (r2_s)
    );

    // r2_d is held high until the synchroniser has refilled after reset, so a
    // ready2 left high across reset is not mistaken for a fresh request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle <= '0;
            r2_d   <= 1'b1;
        end else begin
            settle <= {settle[SYNC_STAGES-2:0], 1'b1};
            if (settle[SYNC_STAGES-1]) r2_d <= r2_s;
        end
    end

    assign r2_rise      = r2_s & ~r2_d;
    assign out_of_range = ({28'd0, cord_x(cords_q)} >= X_SIZE) ||
                          ({28'd0, cord_y(cords_q)} >= Y_SIZE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        ready1_n = ready1;
        hit1_n   = hit1;
        wr_n     = 1'b0;
        wdata_n  = mem_wdata;
        bad_n    = 1'b0;
        dec      = 1'b0;
        latch    = 1'b0;
        case (state)
            S_IDLE: if (r2_rise && enable) begin
                latch   = 1'b1;
                state_n = S_READ;
            end
            S_READ: state_n = S_EVAL;
            S_EVAL: begin
                hit1_n = 1'b0;
                if (out_of_range) begin
                    bad_n = 1'b1;
                end else begin
                    case (cell_t'(mem_rdata))
                        SHIP: begin
                            hit1_n  = 1'b1;
                            wr_n    = 1'b1;
                            wdata_n = HIT;
                            dec     = 1'b1;
                        end
                        EMPTY: begin
                            wr_n    = 1'b1;
                            wdata_n = MISS;
                        end
                        default: ;
                    endcase
                end
                // An aborted request still updates the board but is not acked.
                ready1_n = r2_s;
                state_n  = r2_s ? S_ACK : S_IDLE;
            end
            S_ACK: if (!r2_s) begin
                ready1_n = 1'b0;
                state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        cells_n = cells_left;
        if (new_game)                     cells_n = CL_W'(SHIP_CELLS);
        else if (dec && cells_left != '0) cells_n = cells_left - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cords_q    <= '0;
            ready1     <= 1'b0;
            hit1       <= 1'b0;
            mem_w_nr   <= 1'b0;
            mem_wdata  <= 2'b00;
            bad_cords  <= 1'b0;
            cells_left <= CL_W'(SHIP_CELLS);
            all_sunk   <= 1'b0;
        end else begin
            if (latch) cords_q <= ship_cords_in;
            ready1     <= ready1_n;
            hit1       <= hit1_n;
            mem_w_nr   <= wr_n;
            mem_wdata  <= wdata_n;
            bad_cords  <= bad_n;
            cells_left <= cells_n;
            all_sunk   <= (cells_n == '0);
        end
    end

    assign mem_addr = cords_q;
    assign busy     = (state != S_IDLE) || mem_w_nr;

endmodule
